// File: rtl/mux_scan_pkg.sv
// ============================================================================
// Module   : mux_scan_pkg
// Brief    : Shared constants for the mux channel scanner.
// Revision : 1.0
// ============================================================================
`default_nettype none

package mux_scan_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SCAN = 1'b1;

  localparam logic [1:0] CH_A = 2'd0;
  localparam logic [1:0] CH_B = 2'd1;
  localparam logic [1:0] CH_C = 2'd2;
  localparam logic [1:0] CH_D = 2'd3;

  localparam int DWELL_DEFAULT = 4;

endpackage

`default_nettype wire

// File: rtl/mux_scan_sampler_if.sv
// ============================================================================
// Module   : mux_scan_sampler_if
// Brief    : Control, mux and result signals between scanner and its user.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface mux_scan_sampler_if;
  logic       EN;
  logic       START;
  logic [3:0] MASK;
  logic       Y;
  logic [1:0] S;
  logic [3:0] Q;
  logic       VALID;
  logic       BUSY;

  modport master (
    output EN, START, MASK, Y,
    input  S, Q, VALID, BUSY
  );

  modport slave (
    input  EN, START, MASK, Y,
    output S, Q, VALID, BUSY
  );
endinterface

`default_nettype wire

// File: rtl/mux_next_chan.sv
// ============================================================================
// Module   : mux_next_chan
// Brief    : Finds the lowest enabled channel (first) or the next one above i_cur.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mux_next_chan
  import mux_scan_pkg::*;
(
  input  logic [3:0] i_mask,
  input  logic [1:0] i_cur,
  input  logic       i_first,
  output logic [1:0] o_chan,
  output logic       o_found
);

  // Walk downward so the lowest qualifying channel is the last one written.
  always_comb begin
    o_chan  = CH_A;
    o_found = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (i_mask[i] && (i_first || (i[1:0] > i_cur))) begin
        o_chan  = i[1:0];
        o_found = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/mux_scan_sampler.sv
// ============================================================================
// Module   : mux_scan_sampler
// Brief    : Steps a 4:1 mux through enabled channels, dwells, samples Y and
//            publishes the four samples as one word with a one-cycle strobe.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mux_scan_sampler
  import mux_scan_pkg::*;
#(
  parameter int DWELL = DWELL_DEFAULT,
  parameter int CW    = (DWELL > 2) ? $clog2(DWELL) : 1
) (
  input  logic               CLK,
  input  logic               RST,
  mux_scan_sampler_if.slave  bus
);

  localparam logic [CW-1:0] c_LAST = CW'(DWELL - 1);

  logic [0:0]    r_state;
  logic [0:0]    w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_mask;
  logic [3:0]    r_shadow;
  logic [3:0]    r_q;
  logic [1:0]    r_s;
  logic          r_valid;

  logic          w_first;
  logic [3:0]    w_sel_mask;
  logic [1:0]    w_nxt_ch;
  logic          w_found;
  logic          w_last;
  logic [3:0]    w_shadow_upd;

  // In IDLE the search runs on the live MASK so the first channel is ready
  // on the START edge; during a scan it uses the latched copy.
  assign w_first    = (r_state == ST_IDLE);
  assign w_sel_mask = w_first ? bus.MASK : r_mask;
  assign w_last     = (r_cnt == c_LAST);

  mux_next_chan u_next_chan (
    .i_mask  (w_sel_mask),
    .i_cur   (r_s),
    .i_first (w_first),
    .o_chan  (w_nxt_ch),
    .o_found (w_found)
  );

  always_comb begin
    w_shadow_upd      = r_shadow;
    w_shadow_upd[r_s] = bus.Y;
  end

  always_ff @(posedge CLK) begin
    if (RST) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (bus.START && w_found)           w_state_nxt = ST_SCAN;
      ST_SCAN: if (bus.EN && w_last && !w_found)   w_state_nxt = ST_IDLE;
      default:                                     w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cnt    <= '0;
      r_mask   <= '0;
      r_shadow <= '0;
      r_q      <= '0;
      r_s      <= CH_A;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.START) begin
            if (w_found) begin
              r_mask   <= bus.MASK;
              r_shadow <= '0;
              r_s      <= w_nxt_ch;
              r_cnt    <= '0;
            end else begin
              r_q     <= '0;
              r_valid <= 1'b1;
            end
          end
        end
        ST_SCAN: begin
          if (bus.EN) begin
            if (!w_last) begin
              r_cnt <= r_cnt + CW'(1);
            end else begin
              r_shadow <= w_shadow_upd;
              if (w_found) begin
                r_s   <= w_nxt_ch;
                r_cnt <= '0;
              end else begin
                r_q     <= w_shadow_upd;
                r_valid <= 1'b1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.S     = r_s;
    bus.Q     = r_q;
    bus.VALID = r_valid;
    bus.BUSY  = (r_state == ST_SCAN);
  end

endmodule

`default_nettype wire

// File: tb/tb_mux_scan_sampler.sv
// ============================================================================
// Module   : tb_mux_scan_sampler
// Brief    : Directed bench; a 4:1 mux with A=1 B=0 C=0 D=1 closes the loop.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mux_scan_sampler;

  logic       CLK = 1'b0;
  logic       RST;
  logic [3:0] w_chan = 4'b1001;
  int         n_checks = 0;
  int         n_fail = 0;
  int         exp_s;

  mux_scan_sampler_if bus ();

  mux_scan_sampler #(.DWELL(4)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  assign bus.Y = w_chan[bus.S];

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Accepts START on the next edge (edge 0 of the scan).
  task automatic start_scan(input logic [3:0] mask);
    bus.START = 1'b1;
    bus.MASK  = mask;
    tick();
    bus.START = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    RST       = 1'b1;
    bus.EN    = 1'b0;
    bus.START = 1'b1;
    bus.MASK  = 4'b1111;

    // Reset, with START held alongside it
    repeat (2) tick();
    check("rst_s",     int'(bus.S),     0);
    check("rst_q",     int'(bus.Q),     0);
    check("rst_valid", int'(bus.VALID), 0);
    check("rst_busy",  int'(bus.BUSY),  0);
    RST       = 1'b0;
    bus.START = 1'b0;
    bus.EN    = 1'b1;
    tick();
    check("rst_start_ignored", int'(bus.BUSY), 0);

    // Full scan
    start_scan(4'b1111);
    check("full_busy_e0", int'(bus.BUSY), 1);
    check("full_s_e0",    int'(bus.S),    0);
    for (int e = 1; e < 16; e++) begin
      tick();
      check("full_s",     int'(bus.S),     e / 4);
      check("full_vld_lo", int'(bus.VALID), 0);
      check("full_busy",  int'(bus.BUSY),  1);
    end
    tick();
    check("full_valid", int'(bus.VALID), 1);
    check("full_q",     int'(bus.Q),     9);
    check("full_busy_fall", int'(bus.BUSY), 0);
    check("full_s_hold", int'(bus.S), 3);
    tick();
    check("full_valid_fall", int'(bus.VALID), 0);
    check("full_q_hold",     int'(bus.Q),     9);

    // Sparse scan
    start_scan(4'b1010);
    check("sparse_s_e0", int'(bus.S), 1);
    for (int e = 1; e < 8; e++) begin
      tick();
      check("sparse_s",      int'(bus.S),     (e < 4) ? 1 : 3);
      check("sparse_vld_lo", int'(bus.VALID), 0);
    end
    tick();
    check("sparse_valid", int'(bus.VALID), 1);
    check("sparse_q",     int'(bus.Q),     8);

    // Empty mask
    tick();
    start_scan(4'b0000);
    check("empty_valid", int'(bus.VALID), 1);
    check("empty_q",     int'(bus.Q),     0);
    check("empty_busy",  int'(bus.BUSY),  0);
    tick();
    check("empty_valid_fall", int'(bus.VALID), 0);
    check("empty_busy_after", int'(bus.BUSY),  0);

    // Pause: EN low for edges 9..11 while channel C is selected
    start_scan(4'b1111);
    for (int e = 1; e < 19; e++) begin
      bus.EN = !(e >= 9 && e <= 11);
      tick();
      exp_s = (e < 4) ? 0 : (e < 8) ? 1 : (e < 15) ? 2 : 3;
      check("pause_s",      int'(bus.S),     exp_s);
      check("pause_vld_lo", int'(bus.VALID), 0);
    end
    bus.EN = 1'b1;
    tick();
    check("pause_valid", int'(bus.VALID), 1);
    check("pause_q",     int'(bus.Q),     9);
    tick();

    // Abort at edge 6
    start_scan(4'b1111);
    repeat (5) tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check("abort_q",     int'(bus.Q),     0);
    check("abort_valid", int'(bus.VALID), 0);
    check("abort_busy",  int'(bus.BUSY),  0);
    check("abort_s",     int'(bus.S),     0);
    repeat (3) begin
      tick();
      check("abort_no_valid", int'(bus.VALID), 0);
    end

    // Retrigger: second START at edge 5 ignored, then back-to-back scan
    start_scan(4'b1111);
    repeat (4) tick();
    bus.START = 1'b1;
    bus.MASK  = 4'b0010;
    tick();
    bus.START = 1'b0;
    check("retrig_s_e5", int'(bus.S), 1);
    repeat (10) begin
      tick();
      check("retrig_vld_lo", int'(bus.VALID), 0);
    end
    tick();
    check("retrig_valid", int'(bus.VALID), 1);
    check("retrig_q",     int'(bus.Q),     9);
    start_scan(4'b1000);
    check("b2b_valid_fall", int'(bus.VALID), 0);
    check("b2b_busy",       int'(bus.BUSY),  1);
    check("b2b_s",          int'(bus.S),     3);
    repeat (3) tick();
    check("b2b_vld_lo", int'(bus.VALID), 0);
    tick();
    check("b2b_valid", int'(bus.VALID), 1);
    check("b2b_q",     int'(bus.Q),     8);
    check("b2b_busy_fall", int'(bus.BUSY), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
